eprisc_bus_framer: RTL
======================

Name: eprisc_bus_framer

Overview:
Parametrised byte-serial host-bus front end for the epRISC I/O controller: collects command beats, decodes the address into one-hot peripheral slot enables, and issues a request/acknowledge transaction with timeout. It returns a status beat and read data to the host. It replaces the fixed 7-state load/shift/store pipeline with generic widths, ack-based timing, a full-width read return and error reporting.

Parameters:
BEAT_W, 8, host beat width in bits
ADDR_W, 15, peripheral address width
DATA_W, 16, peripheral data width; must be a multiple of BEAT_W
NUM_SLOTS, 8, number of peripheral slots (one-hot enables)
SLOT_LOG2, 4, log2 of addresses per slot; slot = addr >> SLOT_LOG2
TIMEOUT, 64, maximum request cycles before abort; must be 2 or more

Ports:
iClk  in  1  block clock (single clock domain)
iRst  in  1  asynchronous active-high reset
iSelect  in  1  host frame select; low aborts or idles the frame
iBeatValid  in  1  one-cycle strobe; beat transferred this cycle
iMOSI  in  BEAT_W  host-to-block beat
oMISO  out  BEAT_W  block-to-host beat (valid while oRspValid)
oRspValid  out  1  response phase active
oBusy  out  1  transaction in ISSUE or WAIT
oReq  out  1  peripheral request; held until ack or timeout
iAck  in  1  peripheral acknowledge
oWrite  out  1  write qualifier
oAddr  out  ADDR_W  peripheral address
oWData  out  DATA_W  write data
iRData  in  DATA_W  read data, sampled on the iAck cycle
oSlotEnable  out  NUM_SLOTS  one-hot slot enable, valid with oReq
oSoftReset  out  1  one-cycle soft-reset pulse

Behaviour:
- Command word is {write, addr, data}; CMD_BEATS = (1+ADDR_W+DATA_W)/BEAT_W (4 at defaults). Beats arrive LSB first. A width that is not beat-aligned is an elaboration error.
- Reset (async): state IDLE; oMISO, oRspValid, oBusy, oReq, oWrite, oAddr, oWData, oSlotEnable, oSoftReset all 0; beat counter and status are 0.
- IDLE: if iSelect is high, go to CMD.
- CMD: each iBeatValid&&iSelect shifts in one beat. On the last beat, the next cycle is ISSUE.
- ISSUE/WAIT: oReq=1, oBusy=1, and oAddr/oWData/oWrite/oSlotEnable are driven from registers.
  - On the first cycle with iAck&&oReq: capture iRData (read only; write returns 0), drop oReq the next cycle, go to RESP. Minimum latency is last beat → oReq 1 cycle → ack the same cycle → RESP the next cycle.
  - Timeout: after TIMEOUT request cycles without ack, drop oReq, set status[0], read data = 0, go to RESP.
- Decode: slot = addr>>SLOT_LOG2.
  - If slot >= NUM_SLOTS: no oReq is issued, status[1] is set, go directly to RESP with data 0.
  - If addr is all ones and write=1: pulse oSoftReset for 1 cycle instead of a request. Status is 0 and there is no decode miss.
- RESP: oRspValid=1. RSP_BEATS = 1+DATA_W/BEAT_W.
  - Beat 0 is status: bit0 timeout, bit1 decode miss, bit2 overrun, others 0. Read data follows, LSB first.
  - Each iBeatValid advances oMISO. After the last beat, go to IDLE. iMOSI is ignored in this state.
  - oMISO = 0 whenever oRspValid = 0.
- Overrun: iBeatValid during ISSUE/WAIT is dropped and sets status[2].
- iSelect low:
  - In CMD or RESP: go to IDLE immediately and clear the beat counter.
  - In ISSUE/WAIT: the transaction completes (ack or timeout), then the block goes to IDLE with no response.
- Status clears on entry to CMD. Simultaneous iAck on the timeout cycle: ack wins.

Decomposition:
- Shared package eprisc_io_pkg:
  - state enum (IDLE, CMD, ISSUE, WAIT, RESP)
  - status bit indices
  - soft-reset address constant
  - default slot map (GPIO 0, UART 1, SPI 2, VIDEO 3, RAM 4+)
- One natural sub-module: eprisc_slot_decode, combinational addr → {oSlotEnable, miss}.

Test Plan:
- Read: beats 0x00,0x00,0x21,0x00 (read addr 0x21). iAck on 2nd req cycle with iRData=0xBEEF → oSlotEnable=0x04; response 0x00,0xEF,0xBE.
- Write: beats 0x34,0x12,0x45,0x80 (write addr 0x45, data 0x1234). Immediate ack → oWrite=1, oWData=0x1234, oSlotEnable=0x10; response 0x00,0x00,0x00.
- Timeout: read addr 0x10, iAck held low → oReq high exactly 64 cycles; response 0x01,0x00,0x00.
- Miss/soft reset:
  - Read addr 0x0100 → oReq never asserted; response 0x02.
  - Write addr 0x7FFF → one oSoftReset pulse; response 0x00.
- Abort: iSelect low after 2 beats, then a full new read frame → first frame discarded; second frame completes normally.
- Async reset: assert iRst mid-WAIT → all outputs 0 in the same cycle; next frame behaves as after power-up.

Source files
------------

// File: rtl/eprisc_io_pkg.sv
// Shared definitions for the epRISC I/O controller host-bus front end:
// framer states, status bit positions, soft-reset address and default slot map.
package eprisc_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int STAT_TIMEOUT = 0;
  localparam int STAT_MISS    = 1;
  localparam int STAT_OVERRUN = 2;

  // All-ones address; sliced down to the configured address width by the user
  localparam logic [31:0] SOFT_RESET_ADDR = 32'hFFFF_FFFF;

  localparam int SLOT_GPIO  = 0;
  localparam int SLOT_UART  = 1;
  localparam int SLOT_SPI   = 2;
  localparam int SLOT_VIDEO = 3;
  localparam int SLOT_RAM   = 4;

endpackage

// File: rtl/eprisc_slot_decode.sv
// Combinational address decoder: the upper address bits pick one peripheral
// slot; slot numbers beyond the populated range report a miss.
module eprisc_slot_decode #(
  parameter int ADDR_W    = 15,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_LOG2 = 4
) (
  input  logic [ADDR_W-1:0]    addr_i,
  output logic [NUM_SLOTS-1:0] slotEnable_o,
  output logic                 miss_o
);

  logic [ADDR_W-1:0] slotIdx;

  assign slotIdx = addr_i >> SLOT_LOG2;

  always_comb begin
    miss_o       = (slotIdx >= ADDR_W'(NUM_SLOTS));
    slotEnable_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slotEnable_o[i] = !miss_o && (slotIdx == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/eprisc_bus_framer.sv
// Byte-serial host-bus framer: gathers a {write, addr, data} command, runs one
// req/ack peripheral transaction with timeout, then returns status and read data.
module eprisc_bus_framer
  import eprisc_io_pkg::*;
#(
  parameter int BEAT_W    = 8,
  parameter int ADDR_W    = 15,
  parameter int DATA_W    = 16,
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_LOG2 = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iSelect,
  input  logic                 iBeatValid,
  input  logic [BEAT_W-1:0]    iMOSI,
  output logic [BEAT_W-1:0]    oMISO,
  output logic                 oRspValid,
  output logic                 oBusy,
  output logic                 oReq,
  input  logic                 iAck,
  output logic                 oWrite,
  output logic [ADDR_W-1:0]    oAddr,
  output logic [DATA_W-1:0]    oWData,
  input  logic [DATA_W-1:0]    iRData,
  output logic [NUM_SLOTS-1:0] oSlotEnable,
  output logic                 oSoftReset
);

  localparam int CMD_W     = 1 + ADDR_W + DATA_W;
  localparam int CMD_BEATS = CMD_W / BEAT_W;
  localparam int RSP_BEATS = 1 + DATA_W / BEAT_W;
  localparam int MAX_BEATS = (CMD_BEATS > RSP_BEATS) ? CMD_BEATS : RSP_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int TO_W      = $clog2(TIMEOUT);

  if ((CMD_W % BEAT_W) != 0 || (DATA_W % BEAT_W) != 0) begin : gBadWidth
    $error("eprisc_bus_framer: command and data widths must be beat aligned");
  end
  if (TIMEOUT < 2) begin : gBadTimeout
    $error("eprisc_bus_framer: TIMEOUT must be 2 or more");
  end

  state_t                state_q;
  logic [CMD_W-BEAT_W-1:0] cmd_q;
  logic [CNT_W-1:0]      beatCnt_q;
  logic [TO_W-1:0]       toCnt_q;
  logic [BEAT_W-1:0]     status_q;
  logic [DATA_W-1:0]     rspBuf_q;
  logic                  abort_q;
  logic [BEAT_W-1:0]     oMISO_q;
  logic                  oRspValid_q, oBusy_q, oReq_q, oWrite_q, oSoftReset_q;
  logic [ADDR_W-1:0]     oAddr_q;
  logic [DATA_W-1:0]     oWData_q;
  logic [NUM_SLOTS-1:0]  oSlotEnable_q;

  logic [CMD_W-1:0]      cmdD;
  logic                  nextWrite, isSoftReset, abortNow;
  logic [ADDR_W-1:0]     nextAddr;
  logic [DATA_W-1:0]     nextData, respData;
  logic [BEAT_W-1:0]     statusBusy, statusTimeout, statusMiss;
  logic [NUM_SLOTS-1:0]  decEnable;
  logic                  decMiss;

  // The incoming beat is merged in front of the shift register so the last
  // beat can be decoded in the same cycle it arrives.
  always_comb begin
    cmdD        = {iMOSI, cmd_q};
    nextWrite   = cmdD[CMD_W-1];
    nextAddr    = cmdD[CMD_W-2:DATA_W];
    nextData    = cmdD[DATA_W-1:0];
    isSoftReset = nextWrite && (nextAddr == SOFT_RESET_ADDR[ADDR_W-1:0]);
    abortNow    = abort_q || !iSelect;
    respData    = oWrite_q ? '0 : iRData;
    statusBusy  = status_q;
    if (iBeatValid) statusBusy[STAT_OVERRUN] = 1'b1;
    statusTimeout = statusBusy;
    statusTimeout[STAT_TIMEOUT] = 1'b1;
    statusMiss = status_q;
    statusMiss[STAT_MISS] = 1'b1;
  end

  eprisc_slot_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_SLOTS(NUM_SLOTS),
    .SLOT_LOG2(SLOT_LOG2)
  ) uDecode (
    .addr_i      (nextAddr),
    .slotEnable_o(decEnable),
    .miss_o      (decMiss)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      beatCnt_q     <= '0;
      toCnt_q       <= '0;
      status_q      <= '0;
      rspBuf_q      <= '0;
      abort_q       <= 1'b0;
      oMISO_q       <= '0;
      oRspValid_q   <= 1'b0;
      oBusy_q       <= 1'b0;
      oReq_q        <= 1'b0;
      oWrite_q      <= 1'b0;
      oAddr_q       <= '0;
      oWData_q      <= '0;
      oSlotEnable_q <= '0;
      oSoftReset_q  <= 1'b0;
    end else begin
      oSoftReset_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (iSelect) begin
            state_q   <= CMD;
            beatCnt_q <= '0;
            status_q  <= '0;
          end
        end
        CMD: begin
          if (!iSelect) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
          end else if (iBeatValid) begin
            cmd_q <= cmdD[CMD_W-1:BEAT_W];
            if (beatCnt_q == CNT_W'(CMD_BEATS - 1)) begin
              beatCnt_q <= '0;
              toCnt_q   <= '0;
              abort_q   <= 1'b0;
              if (isSoftReset) begin
                oSoftReset_q <= 1'b1;
                state_q      <= RESP;
                oRspValid_q  <= 1'b1;
                oMISO_q      <= status_q;
                rspBuf_q     <= '0;
              end else if (decMiss) begin
                status_q    <= statusMiss;
                state_q     <= RESP;
                oRspValid_q <= 1'b1;
                oMISO_q     <= statusMiss;
                rspBuf_q    <= '0;
              end else begin
                state_q       <= ISSUE;
                oReq_q        <= 1'b1;
                oBusy_q       <= 1'b1;
                oWrite_q      <= nextWrite;
                oAddr_q       <= nextAddr;
                oWData_q      <= nextData;
                oSlotEnable_q <= decEnable;
              end
            end else begin
              beatCnt_q <= beatCnt_q + CNT_W'(1);
            end
          end
        end
        ISSUE, WAIT: begin
          // Ack is tested before the timeout so a late ack still counts.
          status_q <= statusBusy;
          abort_q  <= abortNow;
          if (iAck || toCnt_q == TO_W'(TIMEOUT - 1)) begin
            oReq_q        <= 1'b0;
            oBusy_q       <= 1'b0;
            oWrite_q      <= 1'b0;
            oAddr_q       <= '0;
            oWData_q      <= '0;
            oSlotEnable_q <= '0;
            beatCnt_q     <= '0;
            if (!iAck) status_q <= statusTimeout;
            if (abortNow) begin
              state_q <= IDLE;
            end else begin
              state_q     <= RESP;
              oRspValid_q <= 1'b1;
              oMISO_q     <= iAck ? statusBusy : statusTimeout;
              rspBuf_q    <= iAck ? respData : '0;
            end
          end else begin
            toCnt_q <= toCnt_q + TO_W'(1);
            state_q <= WAIT;
          end
        end
        RESP: begin
          if (!iSelect || (iBeatValid && beatCnt_q == CNT_W'(RSP_BEATS - 1))) begin
            state_q     <= IDLE;
            oRspValid_q <= 1'b0;
            oMISO_q     <= '0;
            beatCnt_q   <= '0;
          end else if (iBeatValid) begin
            oMISO_q   <= rspBuf_q[BEAT_W-1:0];
            rspBuf_q  <= rspBuf_q >> BEAT_W;
            beatCnt_q <= beatCnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oMISO       = oMISO_q;
  assign oRspValid   = oRspValid_q;
  assign oBusy       = oBusy_q;
  assign oReq        = oReq_q;
  assign oWrite      = oWrite_q;
  assign oAddr       = oAddr_q;
  assign oWData      = oWData_q;
  assign oSlotEnable = oSlotEnable_q;
  assign oSoftReset  = oSoftReset_q;

endmodule
